// File: rtl/dsp_macc_pkg.sv
// dsp_macc_pkg: shared constants and helpers for the dsp_macc_pipe MAC slice.
//   - OPMODE bit positions and the ZSEL (post-adder Z operand) encoding
//   - sat_ovf / sat_narrow: narrow a (P_W+1)-bit signed result to P_W bits,
//     flagging signed overflow and optionally clamping to the signed max/min.
// The helpers take the result width at run time (a constant at each call site)
// so one package serves every P_W up to SAT_MAX_W-1.
package dsp_macc_pkg;

  localparam int OPMODE_W    = 6;
  localparam int OP_ZSEL_LO  = 0;
  localparam int OP_ZSEL_HI  = 1;
  localparam int OP_XSEL     = 2;
  localparam int OP_POST_SUB = 3;
  localparam int OP_PRE_EN   = 4;
  localparam int OP_PRE_SUB  = 5;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'd0,
    ZSEL_P    = 2'd1,
    ZSEL_C    = 2'd2,
    ZSEL_PCIN = 2'd3
  } zsel_e;

  localparam int SAT_MAX_W = 96;
  typedef logic [SAT_MAX_W:0]   sat_in_t;
  typedef logic [SAT_MAX_W-1:0] sat_out_t;
  typedef logic [6:0]           sat_idx_t;

  // r holds the (pw+1)-bit result sign-extended to SAT_MAX_W+1 bits.
  // It fits pw signed bits exactly when its top two bits agree.
  function automatic logic sat_ovf(input sat_in_t r, input sat_idx_t pw);
    return r[pw] != r[pw - 7'd1];
  endfunction

  // Returns the pw-bit result in the low bits; upper bits are zero.
  function automatic sat_out_t sat_narrow(input sat_in_t r, input sat_idx_t pw,
                                          input logic sat_en);
    sat_out_t mask;
    sat_out_t maxv;
    mask = (sat_out_t'(1) << pw) - sat_out_t'(1);
    maxv = mask >> 1;
    if (sat_en && sat_ovf(r, pw))
      return r[pw] ? (mask & ~maxv) : maxv;  // true sign is bit pw
    return r[SAT_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: WIDTH-bit, DEPTH-stage shift register with enable and
// synchronous active-high reset. DEPTH=0 is a straight wire.
//   i_clk  clock (rising edge)
//   i_rst  synchronous reset, priority over i_ce, clears every stage
//   i_ce   advance enable; 0 freezes all stages
//   i_d    data into stage 0
//   o_q    data out of the last stage
module dsp_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_regs
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_ce) begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_macc_pipe.sv
// dsp_macc_pipe: signed pre-add / multiply / post-add-accumulate pipeline.
//   CLK, RST (sync, active-high, priority over CE), CE (global stage enable)
//   IN_VALID qualifies A, B, D, C, PCIN, OPMODE, CIN for this cycle
//   OPMODE: [1:0] ZSEL, [2] XSEL, [3] POST_SUB, [4] PRE_EN, [5] PRE_SUB
//   M: product at the stage feeding P (not gated by valid)
//   P / PCOUT: result register; OVF: overflow of the last loaded result
//   OUT_VALID: P/OVF were loaded on the last edge
// Stages: IN_REGS input registers -> pre-adder + multiplier -> MREG product
// register -> post-adder/saturation -> P. Control and C/PCIN travel with
// their beat so every beat uses its own OPMODE. P_W must be >= A_W+B_W+1,
// >= C_W and < SAT_MAX_W.
module dsp_macc_pipe
  import dsp_macc_pkg::*;
#(
  parameter int A_W     = 18,
  parameter int B_W     = 18,
  parameter int C_W     = 48,
  parameter int P_W     = 48,
  parameter int IN_REGS = 1,
  parameter int MREG    = 1,
  parameter int SAT_EN  = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic                      IN_VALID,
  input  logic signed [A_W-1:0]     A,
  input  logic signed [B_W-1:0]     B,
  input  logic signed [B_W-1:0]     D,
  input  logic signed [C_W-1:0]     C,
  input  logic signed [P_W-1:0]     PCIN,
  input  logic                      CIN,
  input  logic [OPMODE_W-1:0]       OPMODE,
  output logic signed [A_W+B_W:0]   M,
  output logic signed [P_W-1:0]     P,
  output logic signed [P_W-1:0]     PCOUT,
  output logic                      OVF,
  output logic                      OUT_VALID
);

  localparam int M_W  = A_W + B_W + 1;
  localparam int S1_W = 1 + OPMODE_W + 1 + A_W + 2*B_W + C_W + P_W;
  localparam int S2_W = 1 + 4 + 1 + M_W + C_W + P_W;

  // ---------------- input stages ----------------
  logic [S1_W-1:0]          w_s1_bus_d;
  logic [S1_W-1:0]          w_s1_bus_q;
  logic                     w_s1_valid;
  logic [OPMODE_W-1:0]      w_s1_op;
  logic                     w_s1_cin;
  logic signed [A_W-1:0]    w_s1_a;
  logic signed [B_W-1:0]    w_s1_b;
  logic signed [B_W-1:0]    w_s1_dop;
  logic signed [C_W-1:0]    w_s1_c;
  logic signed [P_W-1:0]    w_s1_pcin;

  assign w_s1_bus_d = {IN_VALID, OPMODE, CIN, A, B, D, C, PCIN};

  dsp_pipe_reg #(.WIDTH(S1_W), .DEPTH(IN_REGS)) u_in_regs (
    .i_clk (CLK),
    .i_rst (RST),
    .i_ce  (CE),
    .i_d   (w_s1_bus_d),
    .o_q   (w_s1_bus_q)
  );

  assign {w_s1_valid, w_s1_op, w_s1_cin, w_s1_a, w_s1_b, w_s1_dop,
          w_s1_c, w_s1_pcin} = w_s1_bus_q;

  // ---------------- pre-adder and multiplier ----------------
  logic signed [B_W:0]   w_pre;
  logic signed [M_W-1:0] w_mult;

  always_comb begin
    w_pre = (B_W+1)'(w_s1_b);
    if (w_s1_op[OP_PRE_EN]) begin
      if (w_s1_op[OP_PRE_SUB]) w_pre = (B_W+1)'(w_s1_dop) - (B_W+1)'(w_s1_b);
      else                     w_pre = (B_W+1)'(w_s1_dop) + (B_W+1)'(w_s1_b);
    end
  end

  // Both operands are widened to the full product width, so the truncated
  // signed product is exact.
  assign w_mult = M_W'(w_s1_a) * M_W'(w_pre);

  // ---------------- product stage ----------------
  logic [S2_W-1:0]          w_s2_bus_d;
  logic [S2_W-1:0]          w_s2_bus_q;
  logic                     w_s2_valid;
  logic [3:0]               w_s2_op;
  logic                     w_s2_cin;
  logic signed [M_W-1:0]    w_s2_m;
  logic signed [C_W-1:0]    w_s2_c;
  logic signed [P_W-1:0]    w_s2_pcin;

  assign w_s2_bus_d = {w_s1_valid, w_s1_op[OP_POST_SUB:OP_ZSEL_LO], w_s1_cin,
                       w_mult, w_s1_c, w_s1_pcin};

  dsp_pipe_reg #(.WIDTH(S2_W), .DEPTH(MREG)) u_m_reg (
    .i_clk (CLK),
    .i_rst (RST),
    .i_ce  (CE),
    .i_d   (w_s2_bus_d),
    .o_q   (w_s2_bus_q)
  );

  assign {w_s2_valid, w_s2_op, w_s2_cin, w_s2_m, w_s2_c, w_s2_pcin} = w_s2_bus_q;

  // ---------------- post-adder, saturation, P ----------------
  logic signed [P_W-1:0] r_p;
  logic                  r_ovf;
  logic                  r_out_valid;

  logic signed [P_W:0]   w_x;
  logic signed [P_W:0]   w_z;
  logic signed [P_W:0]   w_xc;
  logic signed [P_W:0]   w_r;
  sat_in_t               w_r_ext;
  logic                  w_ovf;
  logic [P_W-1:0]        w_p_next;

  always_comb begin
    w_x = w_s2_op[OP_XSEL] ? (P_W+1)'(w_s2_m) : '0;
    unique case (w_s2_op[OP_ZSEL_HI:OP_ZSEL_LO])
      ZSEL_P:    w_z = (P_W+1)'(r_p);
      ZSEL_C:    w_z = (P_W+1)'(w_s2_c);
      ZSEL_PCIN: w_z = (P_W+1)'(w_s2_pcin);
      default:   w_z = '0;
    endcase
    w_xc = w_x + {{P_W{1'b0}}, w_s2_cin};
    w_r  = w_s2_op[OP_POST_SUB] ? (w_z - w_xc) : (w_z + w_xc);
  end

  assign w_r_ext  = sat_in_t'(w_r);
  assign w_ovf    = sat_ovf(w_r_ext, sat_idx_t'(P_W));
  assign w_p_next = P_W'(sat_narrow(w_r_ext, sat_idx_t'(P_W), SAT_EN != 0));

  // Only a valid beat on an enabled edge touches P/OVF; bubbles and stalls
  // leave the accumulator alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (CE) begin
      r_out_valid <= w_s2_valid;
      if (w_s2_valid) begin
        r_p   <= w_p_next;
        r_ovf <= w_ovf;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign M         = w_s2_m;
  assign P         = r_p;
  assign PCOUT     = r_p;
  assign OVF       = r_ovf;
  assign OUT_VALID = r_out_valid;

endmodule
